// File: rtl/conv_fmap_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// conv_fmap_buffer: collects one CH-lane beat per handshake, in raster order, into a CH x H x W map.
// A frame handshake (out_vld/out_rdy) follows. Define CONV_FMAP_RELU_EN to clamp negative lanes to zero on write.
module conv_fmap_buffer #(
  parameter  int DW = 8,
  parameter  int CH = 3,
  parameter  int H  = 6,
  parameter  int W  = 6,
  localparam int IW = (H * W > 1) ? $clog2(H * W) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [CH*DW-1:0]         in_data,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [CH*H*W*DW-1:0]     fmap_lin,
  output logic [IW-1:0]            wr_idx
);

  localparam int            HW       = H * W;
  localparam logic [IW-1:0] LAST_IDX = IW'(HW - 1);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]       state;
  logic [CH*DW-1:0] wr_data;
  logic             accept;

  assign in_rdy  = (state == FILL);
  assign out_vld = (state == FULL);
  assign accept  = in_vld & in_rdy;

  for (genvar c = 0; c < CH; c++) begin : g_lane
`ifdef CONV_FMAP_RELU_EN
    assign wr_data[c*DW +: DW] = in_data[c*DW + DW - 1] ? '0 : in_data[c*DW +: DW];
`else
    assign wr_data[c*DW +: DW] = in_data[c*DW +: DW];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= FILL;
      wr_idx <= '0;
    end else if (clr) begin
      state  <= FILL;
      wr_idx <= '0;
    end else if (state == FILL) begin
      if (in_vld) begin
        if (wr_idx == LAST_IDX) begin
          wr_idx <= '0;
          state  <= FULL;
        end else begin
          wr_idx <= wr_idx + IW'(1);
        end
      end
    end else if (out_rdy) begin
      state <= FILL;
    end
  end

  // Every lane of a beat lands at the same raster position in its own channel plane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fmap_lin <= '0;
    end else if (clr) begin
      fmap_lin <= '0;
    end else if (accept) begin
      for (int p = 0; p < HW; p++) begin
        if (wr_idx == IW'(p)) begin
          for (int c = 0; c < CH; c++) begin
            fmap_lin[(c*HW + p)*DW +: DW] <= wr_data[c*DW +: DW];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
